md5_round_seq: RTL
==================

Name: md5_round_seq

Overview:
- Sequencer that walks the 64 MD5 rounds and presents per-round control for LANES rounds per step.
- Per-round control: T constant, message-word index g, rotate amount s, boolean function select f.
- Successor to the combinational T lookup, adding unrolled lanes, a valid/ready step handshake, start/abort/done control and registered outputs.
- Sits between the block controller and the round datapath; the datapath consumes one step per accepted handshake.

Parameters:
- LANES, 1, rounds presented per step. Legal values: 1, 2, 4, 8. Steps per block = 64/LANES.
- SW, 6 (derived, localparam), width of the step counter.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  begin a 64-round sequence; honoured only in IDLE
- abort_i  in  1  synchronous cancel; return to IDLE with no done pulse
- ready_i  in  1  datapath accepts the current step
- valid_o  out  1  step outputs valid
- last_o  out  1  current step contains round 63
- round_o  out  6  round number carried on lane 0
- t_o  out  LANES*32  T constants; lane k in bits [32k:32k+31]
- g_o  out  LANES*4  message word index per lane
- s_o  out  LANES*5  left-rotate amount per lane
- f_o  out  LANES*2  function select per lane: 0=F, 1=G, 2=H, 3=I
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse after the last step is accepted

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, step counter 0, and valid_o, last_o, busy_o, done_o, round_o, t_o, g_o, s_o, f_o all 0.
- States: IDLE, RUN.
  - IDLE with start_i=1 and abort_i=0: enter RUN. Next cycle valid_o=1, busy_o=1, step 0 presented.
  - RUN with valid_o & ready_i: the step is accepted and the counter increments. Outputs for the next step appear the following cycle (registered, one step per cycle at ready_i=1).
  - RUN with valid_o=1 and ready_i=0: all outputs hold stable.
  - Accept with last_o=1: next cycle valid_o=0, busy_o=0, done_o=1 for exactly one cycle, state IDLE.
  - abort_i=1 in any state: next cycle IDLE, valid_o=0, busy_o=0, done_o=0. abort_i has priority over start_i and over the ready_i accept.
- start_i in RUN is ignored; it does not restart the sequence.
- start_i asserted on the same cycle done_o is high (already IDLE): accepted; step 0 valid the next cycle.
- Lane k of step n carries round r = n*LANES + k. round_o = n*LANES.
- Per-round values:
  - f = r[5:4].
  - g: r<16: r mod 16; r<32: (5r+1) mod 16; r<48: (3r+5) mod 16; else (7r) mod 16. All arithmetic mod 16.
  - s, indexed by r mod 4: f=0 → 7,12,17,22; f=1 → 5,9,14,20; f=2 → 4,11,16,23; f=3 → 6,10,15,21.
  - t = floor(abs(sin(r+1))*2^32), from the shared T00..T63 constants.
- last_o=1 iff n = 64/LANES - 1. The counter does not wrap within a sequence; it is cleared to 0 on entry to RUN.
- Outputs in IDLE are 0; values from the final step are not retained.

Test Plan:
- LANES=1, start_i pulse, ready_i=1 → valid_o the next cycle with round_o=0, t_o=0xd76aa478, g=0, s=7, f=0. 64 consecutive valid steps. Step 63 has t_o=0xeb86d391, last_o=1. done_o pulses on the cycle after step 63.
- LANES=1 round checks → round 16: t=0xf61e2562, g=1, s=5, f=1. Round 33: t=0x8771f681, g=8, s=11, f=2. Round 49: t=0x432aff97, g=7, s=10, f=3.
- LANES=4, ready_i=1 → 16 steps. Step 4 presents rounds 16..19 with g=1,6,11,0 and s=5,9,14,20. last_o on step 15 only.
- LANES=1, ready_i toggled pseudo-randomly → every output stable while valid_o & !ready_i. Exactly 64 accepts, no duplicated or skipped round. One done_o pulse.
- abort_i asserted at step 10, then start_i → no done_o; next sequence begins at round 0. start_i during RUN has no effect on the count.
- rst_ni dropped mid-sequence, asynchronous to clk_i → all outputs 0 immediately. After release, idle until start_i.

Source files
------------

// File: rtl/md5_round_seq.sv
// MD5 round sequencer: walks rounds 0..63, LANES rounds per step, and presents the
// per-round T constant, message-word index, rotate amount and boolean function select
// on registered outputs behind a valid/ready step handshake.
module md5_round_seq #(
  parameter int unsigned LANES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic                  last_o,
  output logic [5:0]            round_o,
  output logic [LANES*32-1:0]   t_o,
  output logic [LANES*4-1:0]    g_o,
  output logic [LANES*5-1:0]    s_o,
  output logic [LANES*2-1:0]    f_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int unsigned SW        = 6;
  localparam int unsigned STEPS     = 64 / LANES;
  localparam logic [SW-1:0] LastStep = SW'(STEPS - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e              r_state, w_state_d;
  logic [SW-1:0]       r_step, w_step_d;
  logic                r_valid, r_last, r_busy, r_done;
  logic [5:0]          r_round;
  logic [LANES*32-1:0] r_t;
  logic [LANES*4-1:0]  r_g;
  logic [LANES*5-1:0]  r_s;
  logic [LANES*2-1:0]  r_f;

  logic                w_accept, w_present, w_done_d, w_last_d;
  logic [5:0]          w_round_d;
  logic [LANES*32-1:0] w_t_d;
  logic [LANES*4-1:0]  w_g_d;
  logic [LANES*5-1:0]  w_s_d;
  logic [LANES*2-1:0]  w_f_d;

  // T[r] = floor(abs(sin(r+1)) * 2^32)
  function automatic logic [31:0] t_lut(input logic [5:0] r);
    logic [31:0] t;
    case (r)
      6'd0:  t = 32'hd76aa478;  6'd1:  t = 32'he8c7b756;
      6'd2:  t = 32'h242070db;  6'd3:  t = 32'hc1bdceee;
      6'd4:  t = 32'hf57c0faf;  6'd5:  t = 32'h4787c62a;
      6'd6:  t = 32'ha8304613;  6'd7:  t = 32'hfd469501;
      6'd8:  t = 32'h698098d8;  6'd9:  t = 32'h8b44f7af;
      6'd10: t = 32'hffff5bb1;  6'd11: t = 32'h895cd7be;
      6'd12: t = 32'h6b901122;  6'd13: t = 32'hfd987193;
      6'd14: t = 32'ha679438e;  6'd15: t = 32'h49b40821;
      6'd16: t = 32'hf61e2562;  6'd17: t = 32'hc040b340;
      6'd18: t = 32'h265e5a51;  6'd19: t = 32'he9b6c7aa;
      6'd20: t = 32'hd62f105d;  6'd21: t = 32'h02441453;
      6'd22: t = 32'hd8a1e681;  6'd23: t = 32'he7d3fbc8;
      6'd24: t = 32'h21e1cde6;  6'd25: t = 32'hc33707d6;
      6'd26: t = 32'hf4d50d87;  6'd27: t = 32'h455a14ed;
      6'd28: t = 32'ha9e3e905;  6'd29: t = 32'hfcefa3f8;
      6'd30: t = 32'h676f02d9;  6'd31: t = 32'h8d2a4c8a;
      6'd32: t = 32'hfffa3942;  6'd33: t = 32'h8771f681;
      6'd34: t = 32'h6d9d6122;  6'd35: t = 32'hfde5380c;
      6'd36: t = 32'ha4beea44;  6'd37: t = 32'h4bdecfa9;
      6'd38: t = 32'hf6bb4b60;  6'd39: t = 32'hbebfbc70;
      6'd40: t = 32'h289b7ec6;  6'd41: t = 32'heaa127fa;
      6'd42: t = 32'hd4ef3085;  6'd43: t = 32'h04881d05;
      6'd44: t = 32'hd9d4d039;  6'd45: t = 32'he6db99e5;
      6'd46: t = 32'h1fa27cf8;  6'd47: t = 32'hc4ac5665;
      6'd48: t = 32'hf4292244;  6'd49: t = 32'h432aff97;
      6'd50: t = 32'hab9423a7;  6'd51: t = 32'hfc93a039;
      6'd52: t = 32'h655b59c3;  6'd53: t = 32'h8f0ccc92;
      6'd54: t = 32'hffeff47d;  6'd55: t = 32'h85845dd1;
      6'd56: t = 32'h6fa87e4f;  6'd57: t = 32'hfe2ce6e0;
      6'd58: t = 32'ha3014314;  6'd59: t = 32'h4e0811a1;
      6'd60: t = 32'hf7537e82;  6'd61: t = 32'hbd3af235;
      6'd62: t = 32'h2ad7d2bb;  6'd63: t = 32'heb86d391;
      default: t = 32'h0;
    endcase
    return t;
  endfunction

  // Message-word index; only r mod 16 matters since all arithmetic is mod 16
  function automatic logic [3:0] g_calc(input logic [5:0] r);
    logic [3:0] r4;
    logic [3:0] g;
    r4 = r[3:0];
    case (r[5:4])
      2'd0:    g = r4;
      2'd1:    g = r4 * 4'd5 + 4'd1;
      2'd2:    g = r4 * 4'd3 + 4'd5;
      default: g = r4 * 4'd7;
    endcase
    return g;
  endfunction

  // Rotate amount, selected by function group and r mod 4
  function automatic logic [4:0] s_calc(input logic [5:0] r);
    logic [4:0] s;
    case ({r[5:4], r[1:0]})
      4'h0: s = 5'd7;   4'h1: s = 5'd12;  4'h2: s = 5'd17;  4'h3: s = 5'd22;
      4'h4: s = 5'd5;   4'h5: s = 5'd9;   4'h6: s = 5'd14;  4'h7: s = 5'd20;
      4'h8: s = 5'd4;   4'h9: s = 5'd11;  4'ha: s = 5'd16;  4'hb: s = 5'd23;
      4'hc: s = 5'd6;   4'hd: s = 5'd10;  4'he: s = 5'd15;  default: s = 5'd21;
    endcase
    return s;
  endfunction

  assign w_accept = r_valid & ready_i;

  // Next state and step counter; abort beats start and accept
  always_comb begin
    w_state_d = r_state;
    w_step_d  = r_step;
    w_done_d  = 1'b0;
    if (abort_i) begin
      w_state_d = StIdle;
      w_step_d  = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start_i) begin
            w_state_d = StRun;
            w_step_d  = '0;
          end
        end
        StRun: begin
          if (w_accept) begin
            if (r_last) begin
              w_state_d = StIdle;
              w_step_d  = '0;
              w_done_d  = 1'b1;
            end else begin
              w_step_d = r_step + 1'b1;
            end
          end
        end
        default: begin
          w_state_d = StIdle;
          w_step_d  = '0;
        end
      endcase
    end
  end

  assign w_present = (w_state_d == StRun);

  // Per-lane control for the step that will be presented next cycle; zero when idle
  always_comb begin
    logic [5:0] lane_r;
    w_t_d     = '0;
    w_g_d     = '0;
    w_s_d     = '0;
    w_f_d     = '0;
    w_round_d = '0;
    w_last_d  = 1'b0;
    lane_r    = '0;
    if (w_present) begin
      w_round_d = 6'(w_step_d * LANES);
      w_last_d  = (w_step_d == LastStep);
      for (int k = 0; k < int'(LANES); k++) begin
        lane_r            = 6'(w_step_d * LANES + 32'(k));
        w_t_d[32*k +: 32] = t_lut(lane_r);
        w_g_d[4*k +: 4]   = g_calc(lane_r);
        w_s_d[5*k +: 5]   = s_calc(lane_r);
        w_f_d[2*k +: 2]   = lane_r[5:4];
      end
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_step  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_round <= '0;
      r_t     <= '0;
      r_g     <= '0;
      r_s     <= '0;
      r_f     <= '0;
    end else begin
      r_state <= w_state_d;
      r_step  <= w_step_d;
      r_valid <= w_present;
      r_busy  <= w_present;
      r_last  <= w_last_d;
      r_done  <= w_done_d;
      r_round <= w_round_d;
      r_t     <= w_t_d;
      r_g     <= w_g_d;
      r_s     <= w_s_d;
      r_f     <= w_f_d;
    end
  end

  assign valid_o = r_valid;
  assign busy_o  = r_busy;
  assign last_o  = r_last;
  assign done_o  = r_done;
  assign round_o = r_round;
  assign t_o     = r_t;
  assign g_o     = r_g;
  assign s_o     = r_s;
  assign f_o     = r_f;

endmodule
